floo_vc_credit_sched: RTL and testbench
=======================================

# floo_vc_credit_sched

Credit-based virtual-channel scheduler that shares one physical flit link between `NumVirtChannels` requesters. Typical requesters are the per-VC spill registers of a link cut. It keeps one downstream credit counter per VC and picks among eligible VCs by round robin. Each granted flit goes out through a registered output stage tagged with its VC id. It sits at the sending end of a credit-flow-controlled link, in place of a ready/valid VC arbiter.

## Interface
Parameters:
- `NumVirtChannels`, default 2: number of VCs; must be ≥ 2.
- `NumCredits`, default 4: downstream buffer depth per VC; this is the credit counter reset value. Must be ≥ 1.
- `flit_t`, default `logic`: flit payload type.
- `CntWidth`, default `$clog2(NumCredits+1)`: credit counter width (derived; do not override).
- `IdWidth`, default `$clog2(NumVirtChannels)`: VC id width (derived).

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset; asynchronous, active-low.
- `valid_i`  in  `NumVirtChannels`: per-VC flit valid.
- `ready_o`  out  `NumVirtChannels`: per-VC grant; at most one bit high.
- `data_i`  in  `flit_t [NumVirtChannels]`: per-VC flit.
- `last_i`  in  `NumVirtChannels`: per-VC last-flit-of-packet marker.
- `credit_i`  in  `NumVirtChannels`: per-VC credit-return pulse from downstream; one credit per cycle high.
- `valid_o`  out  1: flit on the link. There is no ready; credits guarantee acceptance.
- `data_o`  out  `flit_t`: link flit.
- `vc_id_o`  out  `IdWidth`: VC of `data_o`.
- `last_o`  out  1: last marker of `data_o`.
- `credit_err_o`  out  1: sticky flag; credit returned to a counter already at `NumCredits`.

## Operation
- A VC v is eligible when `valid_i[v]` is high and `cnt_q[v] > 0`.
- Round robin:
  - Grant goes to the first eligible VC scanning cyclically from `rr_q`.
  - `ready_o[v]` is high only for the granted VC.
  - After a grant to v, `rr_q <= (v+1) mod NumVirtChannels`.
- Credit counter update, per VC:
  - Grant only: decrement.
  - `credit_i` only: increment.
  - Both in the same cycle: unchanged.
  - Neither: unchanged.
- Credit overflow: `credit_i[v]` with `cnt_q[v] == NumCredits` and no grant on v.
  - The counter saturates (stays at `NumCredits`).
  - `credit_err_o` is set and stays high until reset.
- Output stage, updated every cycle:
  - `valid_o <= |ready_o`.
  - On a grant, `data_o`, `vc_id_o` and `last_o` load the granted VC's values.
  - Without a grant they hold their previous values.
- `last_i` is always forwarded to `last_o`. It affects arbitration only under the Configuration macro.
- Reset, asynchronous and possible mid-operation:
  - `cnt_q[*] = NumCredits`, `rr_q = 0`, lock cleared.
  - `valid_o = 0`, `data_o = '0`, `vc_id_o = 0`, `last_o = 0`, `credit_err_o = 0`.
  - `ready_o` is forced to 0 while `rst_ni` is low.
  - Flits in flight downstream are not tracked; the whole link must be reset together.

## Timing
- `ready_o` is combinational from `valid_i` and registered state (`cnt_q`, `rr_q`, lock).
  - `ready_o` may depend on `valid_i`; upstream `valid_i` must not depend on `ready_o`.
  - `credit_i` never affects `ready_o` in the same cycle; a returned credit can enable a grant from the next cycle.
- Latency: a handshake in cycle t (`valid_i[v] & ready_o[v]`) produces `valid_o = 1` with that flit in cycle t+1.
- Throughput: 1 flit/cycle aggregate.
- A single VC sustains 1 flit/cycle only while credits keep returning.
- With no credits returned, a VC sends exactly `cnt_q[v]` flits and then stalls.
- `valid_o` is a single-cycle pulse per flit; back-to-back flits give a continuous high.

## Configuration
- Macro `FLOO_VC_CREDIT_SCHED_LOCK_EN` (wormhole lock).
- Defined:
  - A grant to VC v with `last_i[v] == 0` locks the scheduler to v.
  - While locked, only v can be granted, even when v is not eligible and others are; the link idles meanwhile.
  - The grant with `last_i[v] == 1` releases the lock, and `rr_q` advances only on that release grant.
- Undefined: no lock state is built. Arbitration is per flit and `last_i` only feeds `last_o`.

## Test plan
- **Reset/credit init** (`NumCredits=4`, `NumVirtChannels=2`): after reset release, `valid_o=0` and `credit_err_o=0`. Then `valid_i[0]=1` held with no `credit_i` gives exactly 4 `valid_o` pulses with `vc_id_o=0`, then `ready_o[0]=0` indefinitely.
- **Credit return**: from the exhausted state, one pulse on `credit_i[0]` at cycle t gives `ready_o[0]=1` at t+1 and `valid_o=1` at t+2, once only.
- **Fairness**: both VCs valid continuously with `credit_i` high every cycle on both gives `vc_id_o` = 0,1,0,1,… with `valid_o` high every cycle.
- **Simultaneous grant and credit**: VC1 at count 1 is granted while `credit_i[1]=1` in the same cycle; the count stays 1 and VC1 is eligible again next cycle.
- **Lock**: VC0 sends a 3-flit packet (`last_i` high on the third) while VC1 is valid throughout, credits plentiful.
  - Macro defined: `vc_id_o` = 0,0,0,1.
  - Macro undefined: `vc_id_o` = 0,1,0,1.
- **Overflow**: `credit_i[1]` pulsed at count 4 sets `credit_err_o=1`, the count stays 4, and the flag persists; asserting `rst_ni=0` mid-traffic clears it and clears `valid_o` immediately.

Source files
------------

// File: rtl/floo_vc_credit_sched.sv
// Credit-based round-robin VC scheduler driving one registered flit link.
// Define FLOO_VC_CREDIT_SCHED_LOCK_EN to hold the grant on one VC until its last flit (wormhole lock).
module floo_vc_credit_sched #(
  parameter int unsigned NumVirtChannels = 2,
  parameter int unsigned NumCredits      = 4,
  parameter type         flit_t          = logic,
  parameter int unsigned CntWidth        = $clog2(NumCredits + 1),
  parameter int unsigned IdWidth         = $clog2(NumVirtChannels)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumVirtChannels-1:0] valid_i,
  output logic [NumVirtChannels-1:0] ready_o,
  input  flit_t                      data_i [NumVirtChannels],
  input  logic [NumVirtChannels-1:0] last_i,
  input  logic [NumVirtChannels-1:0] credit_i,
  output logic                       valid_o,
  output flit_t                      data_o,
  output logic [IdWidth-1:0]         vc_id_o,
  output logic                       last_o,
  output logic                       credit_err_o
);

  typedef logic [CntWidth-1:0] cnt_t;
  localparam cnt_t MaxCnt = cnt_t'(NumCredits);

  cnt_t                       cnt_q [NumVirtChannels];
  cnt_t                       cnt_d [NumVirtChannels];
  logic [IdWidth-1:0]         rr_q, rr_d;
  logic                       err_q, err_d;
  logic [NumVirtChannels-1:0] elig, gnt_oh;
  logic [IdWidth-1:0]         gnt_idx, scan_idx, rr_nxt;
  logic                       gnt_vld;

  logic                       valid_q;
  flit_t                      data_q;
  logic [IdWidth-1:0]         vc_q;
  logic                       last_q;

`ifdef FLOO_VC_CREDIT_SCHED_LOCK_EN
  logic                       lock_q, lock_d;
  logic [IdWidth-1:0]         lock_vc_q, lock_vc_d;
`endif

  always_comb begin
    for (int unsigned v = 0; v < NumVirtChannels; v++) begin
      elig[v] = valid_i[v] && (cnt_q[v] != '0);
`ifdef FLOO_VC_CREDIT_SCHED_LOCK_EN
      // A locked link idles rather than interleaving another VC mid-packet.
      if (lock_q && (IdWidth'(v) != lock_vc_q)) elig[v] = 1'b0;
`endif
    end
  end

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NumVirtChannels; i++) begin
      scan_idx = IdWidth'((32'(rr_q) + i) % NumVirtChannels);
      if (!gnt_vld && elig[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    rr_nxt = IdWidth'((32'(gnt_idx) + 1) % NumVirtChannels);
  end

  assign ready_o = rst_ni ? gnt_oh : '0;

  always_comb begin
    err_d = err_q;
    rr_d  = rr_q;
    for (int unsigned v = 0; v < NumVirtChannels; v++) begin
      cnt_d[v] = cnt_q[v];
      if (gnt_oh[v] && !credit_i[v]) begin
        cnt_d[v] = cnt_q[v] - cnt_t'(1);
      end else if (!gnt_oh[v] && credit_i[v]) begin
        if (cnt_q[v] == MaxCnt) err_d = 1'b1;
        else                    cnt_d[v] = cnt_q[v] + cnt_t'(1);
      end
    end
`ifdef FLOO_VC_CREDIT_SCHED_LOCK_EN
    lock_d    = lock_q;
    lock_vc_d = lock_vc_q;
    if (gnt_vld) begin
      if (last_i[gnt_idx]) begin
        lock_d = 1'b0;
        rr_d   = rr_nxt;
      end else begin
        lock_d    = 1'b1;
        lock_vc_d = gnt_idx;
      end
    end
`else
    if (gnt_vld) rr_d = rr_nxt;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned v = 0; v < NumVirtChannels; v++) cnt_q[v] <= MaxCnt;
      rr_q    <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      vc_q    <= '0;
      last_q  <= 1'b0;
`ifdef FLOO_VC_CREDIT_SCHED_LOCK_EN
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
`endif
    end else begin
      for (int unsigned v = 0; v < NumVirtChannels; v++) cnt_q[v] <= cnt_d[v];
      rr_q    <= rr_d;
      err_q   <= err_d;
      valid_q <= gnt_vld;
      if (gnt_vld) begin
        data_q <= data_i[gnt_idx];
        vc_q   <= gnt_idx;
        last_q <= last_i[gnt_idx];
      end
`ifdef FLOO_VC_CREDIT_SCHED_LOCK_EN
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
`endif
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign vc_id_o      = vc_q;
  assign last_o       = last_q;
  assign credit_err_o = err_q;

endmodule

// File: tb/tb_floo_vc_credit_sched.sv
// Scoreboard bench for floo_vc_credit_sched: directed stimulus pushes expected link flits,
// a negedge monitor pops and compares every valid_o beat.
module tb_floo_vc_credit_sched;
  localparam int unsigned NV = 2;
  localparam int unsigned NC = 4;
  typedef logic [7:0] flit_t;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [NV-1:0] valid_i, ready_o, last_i, credit_i;
  flit_t         data_i [NV];
  logic          valid_o;
  flit_t         data_o;
  logic [0:0]    vc_id_o;
  logic          last_o, credit_err_o;

  typedef struct packed {
    logic [0:0] vc;
    flit_t      data;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   n_flits = 0;

  always #5 clk = ~clk;

  floo_vc_credit_sched #(
    .NumVirtChannels(NV),
    .NumCredits     (NC),
    .flit_t         (flit_t)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .last_i      (last_i),
    .credit_i    (credit_i),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .vc_id_o     (vc_id_o),
    .last_o      (last_o),
    .credit_err_o(credit_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int vc, input flit_t d, input logic l);
    exp_t e;
    e.vc   = 1'(vc);
    e.data = d;
    e.last = l;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && valid_o) begin
        n_flits++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL flit_unexpected: got vc=%0d data=%0h last=%0b expected none",
                   vc_id_o, data_o, last_o);
        end else begin
          e = q.pop_front();
          chk("flit{vc,data,last}", 32'({vc_id_o, data_o, last_o}), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int base, gcnt, idx, n1;
    valid_i   = '0;
    last_i    = '0;
    credit_i  = '0;
    data_i[0] = '0;
    data_i[1] = '0;

    // Reset: grants suppressed while rst_ni low even with full credits
    valid_i = 2'b11;
    repeat (2) @(negedge clk);
    chk("ready_in_reset", 32'(ready_o), 32'(2'b00));
    chk("valid_o_in_reset", 32'(valid_o), 32'(1'b0));
    valid_i = '0;
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    chk("valid_o_after_reset", 32'(valid_o), 32'(1'b0));
    chk("err_after_reset", 32'(credit_err_o), 32'(1'b0));

    // Credit init: exactly NC flits then stall
    data_i[0] = 8'h11;
    last_i    = 2'b11;
    for (int k = 0; k < 4; k++) push(0, 8'h11, 1'b1);
    base = n_flits;
    gcnt = 0;
    tick();
    valid_i = 2'b01;
    repeat (8) begin
      @(negedge clk);
      if (ready_o[0]) gcnt++;
    end
    chk("init_grants", 32'(gcnt), 32'(4));
    chk("init_stalled", 32'(ready_o), 32'(2'b00));
    chk("init_pulses", 32'(n_flits - base), 32'(4));

    // Credit return: visible to arbitration one cycle later, single flit
    tick();
    credit_i = 2'b01;
    @(negedge clk);
    chk("credit_same_cycle", 32'(ready_o), 32'(2'b00));
    tick();
    credit_i = 2'b00;
    @(negedge clk);
    chk("credit_next_cycle", 32'(ready_o), 32'(2'b01));
    push(0, 8'h11, 1'b1);
    tick();
    @(negedge clk);
    chk("credit_once", 32'(ready_o), 32'(2'b00));
    chk("credit_valid_o", 32'(valid_o), 32'(1'b1));
    tick();
    valid_i = '0;
    @(negedge clk);
    chk("credit_valid_o_pulse", 32'(valid_o), 32'(1'b0));

    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;

    // Fairness: each grant's credit returns the following cycle
    data_i[0] = 8'h20;
    data_i[1] = 8'h21;
    for (int k = 0; k < 8; k++) push(k % 2, (k % 2 == 1) ? 8'h21 : 8'h20, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      valid_i  = 2'b11;
      credit_i = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      @(negedge clk);
      chk("fair_ready", 32'(ready_o), (k % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
      if (k > 0) chk("fair_valid_o", 32'(valid_o), 32'(1'b1));
    end
    tick();
    valid_i  = '0;
    credit_i = 2'b10;
    @(negedge clk);
    chk("fair_valid_o_last", 32'(valid_o), 32'(1'b1));
    chk("fair_no_err", 32'(credit_err_o), 32'(1'b0));
    tick();
    credit_i = '0;

    // Simultaneous grant and credit at count 1
    data_i[1] = 8'h31;
    for (int k = 0; k < 5; k++) push(1, 8'h31, 1'b1);
    valid_i = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    credit_i = 2'b10;
    @(negedge clk);
    chk("simul_grant", 32'(ready_o), 32'(2'b10));
    tick();
    credit_i = '0;
    @(negedge clk);
    chk("simul_eligible", 32'(ready_o), 32'(2'b10));
    tick();
    @(negedge clk);
    chk("simul_exhausted", 32'(ready_o), 32'(2'b00));
    tick();
    valid_i  = '0;
    credit_i = 2'b10;
    repeat (3) tick();
    tick();
    credit_i = '0;

    // Lock: VC0 3-flit packet against continuously valid VC1
    data_i[1] = 8'h61;
`ifdef FLOO_VC_CREDIT_SCHED_LOCK_EN
    push(0, 8'h50, 1'b0);
    push(0, 8'h51, 1'b0);
    push(0, 8'h52, 1'b1);
    push(1, 8'h61, 1'b1);
    n1 = 1;
`else
    push(0, 8'h50, 1'b0);
    push(1, 8'h61, 1'b1);
    push(0, 8'h51, 1'b0);
    push(1, 8'h61, 1'b1);
    push(0, 8'h52, 1'b1);
    n1 = 2;
`endif
    idx = 0;
    for (int c = 0; c < 12 && (idx < 3 || c < 4); c++) begin
      tick();
      valid_i[1] = (c < 4);
      valid_i[0] = (idx < 3);
      data_i[0]  = 8'(8'h50 + idx);
      last_i[0]  = (idx == 2);
      @(negedge clk);
      if (ready_o[0]) idx++;
    end
    tick();
    valid_i = '0;
    last_i  = 2'b11;
    chk("lock_vc0_done", 32'(idx), 32'(3));
    for (int k = 0; k < 3; k++) begin
      credit_i = {(k < n1), 1'b1};
      tick();
    end
    credit_i = '0;

    // Overflow: saturate at NC, sticky flag
    chk("err_before_overflow", 32'(credit_err_o), 32'(1'b0));
    tick();
    credit_i = 2'b10;
    tick();
    credit_i = '0;
    @(negedge clk);
    chk("err_set", 32'(credit_err_o), 32'(1'b1));
    data_i[1] = 8'h71;
    for (int k = 0; k < 4; k++) push(1, 8'h71, 1'b1);
    gcnt = 0;
    tick();
    valid_i = 2'b10;
    repeat (7) begin
      @(negedge clk);
      if (ready_o[1]) gcnt++;
    end
    chk("overflow_saturated", 32'(gcnt), 32'(4));
    chk("err_sticky", 32'(credit_err_o), 32'(1'b1));

    // Mid-traffic asynchronous reset
    data_i[0] = 8'h81;
    tick();
    valid_i = 2'b01;
    @(negedge clk);
    chk("pre_reset_grant", 32'(ready_o), 32'(2'b01));
    tick();
    chk("pre_reset_valid_o", 32'(valid_o), 32'(1'b1));
    rst_ni = 1'b0;
    #1;
    chk("reset_valid_o", 32'(valid_o), 32'(1'b0));
    chk("reset_err", 32'(credit_err_o), 32'(1'b0));
    chk("reset_ready", 32'(ready_o), 32'(2'b00));
    tick();
    valid_i = '0;
    rst_ni  = 1'b1;
    @(negedge clk);
    chk("post_reset_err", 32'(credit_err_o), 32'(1'b0));

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
